// File: rtl/ca_run_sequencer.sv
// ca_run_sequencer
//   Runs the 8-bit two-neighbour cellular-automaton step (catwocode) for a
//   requested number of generations. It captures rule/seed/gens on start and
//   holds the CA state in a register. Each accepted output beat applies one
//   generation. Each new generation is streamed out on a valid/ready port, and
//   done pulses when the run completes.
//
//   Optional build macro: CA_FIXPOINT_EN
//     Defined: a beat whose next generation equals the current state ends the
//     run early, and the sticky output 'fixpoint' reports it.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           run request, sampled only in IDLE
//   abort           cancel run (RUN/FIN -> IDLE), beats start in IDLE
//   rule[3:0]       CA rule, captured on start
//   seed[7:0]       initial state, captured on start
//   gens[GEN_W-1:0] generations to run, captured on start
//   out_valid       out_data holds the next generation (high in RUN)
//   out_ready       consumer accepts out_data when out_valid & out_ready
//   out_data[7:0]   next generation = catwocode(state_q, rule_q)
//   state_q[7:0]    current registered CA state
//   gen_cnt         generations completed in this run
//   busy            high in RUN
//   done            one-cycle pulse on completion (suppressed by abort)
//   fixpoint        (CA_FIXPOINT_EN only) run ended on a fixed point
module ca_run_sequencer #(
  parameter int GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       rule,
  input  logic [7:0]       seed,
  input  logic [GEN_W-1:0] gens,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [7:0]       state_q,
  output logic [GEN_W-1:0] gen_cnt,
  output logic             busy,
  output logic             done
`ifdef CA_FIXPOINT_EN
  ,
  output logic             fixpoint
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } fsm_t;

  fsm_t             fsm_q,     fsm_d;
  logic [3:0]       rule_q,    rule_d;
  logic [GEN_W-1:0] gens_q,    gens_d;
  logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
  logic [7:0]       state_d;
  logic [GEN_W-1:0] gen_inc;
`ifdef CA_FIXPOINT_EN
  logic             fixpoint_q, fixpoint_d;
`endif

  // Each cell i looks at itself and its left neighbour (i+1, wrapping);
  // that 2-bit pattern selects one bit of the rule.
  function automatic logic [7:0] catwocode(input logic [7:0] a,
                                           input logic [3:0] b);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = b[{a[(i + 1) % 8], a[i]}];
    end
    return y;
  endfunction

  assign gen_inc = gen_cnt_q + {{(GEN_W-1){1'b0}}, 1'b1};

  always_comb begin
    fsm_d     = fsm_q;
    rule_d    = rule_q;
    gens_d    = gens_q;
    gen_cnt_d = gen_cnt_q;
    state_d   = state_q;
`ifdef CA_FIXPOINT_EN
    fixpoint_d = fixpoint_q;
`endif
    out_data  = catwocode(state_q, rule_q);

    case (fsm_q)
      IDLE: begin
        // abort in IDLE outranks start
        if (start && !abort) begin
          rule_d    = rule;
          state_d   = seed;
          gens_d    = gens;
          gen_cnt_d = '0;
`ifdef CA_FIXPOINT_EN
          fixpoint_d = 1'b0;
`endif
          fsm_d     = (gens == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          fsm_d = IDLE;
        end else if (out_ready) begin
          state_d   = out_data;
          gen_cnt_d = gen_inc;
          if (gen_inc == gens_q) begin
            fsm_d = FIN;
          end
`ifdef CA_FIXPOINT_EN
          // A state that maps onto itself will never change again.
          if (out_data == state_q) begin
            fsm_d      = FIN;
            fixpoint_d = 1'b1;
          end
`endif
        end
      end
      FIN: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      rule_q    <= '0;
      gens_q    <= '0;
      gen_cnt_q <= '0;
      state_q   <= '0;
`ifdef CA_FIXPOINT_EN
      fixpoint_q <= 1'b0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      rule_q    <= rule_d;
      gens_q    <= gens_d;
      gen_cnt_q <= gen_cnt_d;
      state_q   <= state_d;
`ifdef CA_FIXPOINT_EN
      fixpoint_q <= fixpoint_d;
`endif
    end
  end

  assign out_valid = (fsm_q == RUN);
  assign busy      = (fsm_q == RUN);
  // An abort arriving during FIN cancels the completion pulse.
  assign done      = (fsm_q == FIN) && !abort;
  assign gen_cnt   = gen_cnt_q;
`ifdef CA_FIXPOINT_EN
  assign fixpoint  = fixpoint_q;
`endif

endmodule
